// File: rtl/axi_lite_arbiter_n_if.sv
// Bus bundle for the N-master AXI-Lite arbiter: packed per-master channels plus the single slave port.
// The arbiter takes the slave modport; the surrounding masters/slave drive the master modport.
interface axi_lite_arbiter_n_if #(
    parameter int unsigned NM = 2,
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    // Master side
    logic [NM-1:0]        m_arvalid;
    logic [NM-1:0]        m_arready;
    logic [NM*AW-1:0]     m_araddr;
    logic [NM-1:0]        m_rvalid;
    logic [NM-1:0]        m_rready;
    logic [DW-1:0]        m_rdata;
    logic                 m_rresp;
    logic [NM-1:0]        m_awvalid;
    logic [NM-1:0]        m_awready;
    logic [NM*AW-1:0]     m_awaddr;
    logic [NM-1:0]        m_wvalid;
    logic [NM-1:0]        m_wready;
    logic [NM*DW-1:0]     m_wdata;
    logic [NM*DW/8-1:0]   m_wstrb;
    logic [NM-1:0]        m_bvalid;
    logic [NM-1:0]        m_bready;
    logic                 m_bresp;

    // Slave side
    logic                 s_arvalid;
    logic                 s_arready;
    logic [AW-1:0]        s_araddr;
    logic                 s_rvalid;
    logic                 s_rready;
    logic [DW-1:0]        s_rdata;
    logic                 s_rresp;
    logic                 s_awvalid;
    logic                 s_awready;
    logic [AW-1:0]        s_awaddr;
    logic                 s_wvalid;
    logic                 s_wready;
    logic [DW-1:0]        s_wdata;
    logic [DW/8-1:0]      s_wstrb;
    logic                 s_bvalid;
    logic                 s_bready;
    logic                 s_bresp;

    modport slave (
        input  m_arvalid, m_araddr, m_rready, m_awvalid, m_awaddr, m_wvalid, m_wdata, m_wstrb,
        input  m_bready,
        input  s_arready, s_rvalid, s_rdata, s_rresp, s_awready, s_wready, s_bvalid, s_bresp,
        output m_arready, m_rvalid, m_rdata, m_rresp, m_awready, m_wready, m_bvalid, m_bresp,
        output s_arvalid, s_araddr, s_rready, s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb,
        output s_bready
    );

    modport master (
        output m_arvalid, m_araddr, m_rready, m_awvalid, m_awaddr, m_wvalid, m_wdata, m_wstrb,
        output m_bready,
        output s_arready, s_rvalid, s_rdata, s_rresp, s_awready, s_wready, s_bvalid, s_bresp,
        input  m_arready, m_rvalid, m_rdata, m_rresp, m_awready, m_wready, m_bvalid, m_bresp,
        input  s_arvalid, s_araddr, s_rready, s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb,
        input  s_bready
    );
endinterface

// File: rtl/axi_lite_arbiter_n.sv
// N-master to one-slave AXI-Lite arbiter with independent read and write arbiters.
// Define AXI_ARB_ROUND_ROBIN_EN for round-robin; otherwise the lowest requesting index wins.
module axi_lite_arbiter_n #(
    parameter int unsigned NM = 2,
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input logic                 clk,
    input logic                 reset,
    axi_lite_arbiter_n_if.slave bus_io
);
    localparam int unsigned GW = (NM > 2) ? $clog2(NM) : 1;
    localparam int unsigned SW = DW / 8;

    typedef enum logic [1:0] {RdIdle, RdAddr, RdData} rd_state_e;
    typedef enum logic [1:0] {WrIdle, WrReq, WrResp} wr_state_e;

    rd_state_e     rd_state_q, rd_state_d;
    wr_state_e     wr_state_q, wr_state_d;
    logic [GW-1:0] rgnt_q, rgnt_d;
    logic [GW-1:0] wgnt_q, wgnt_d;
    logic          aw_done_q, aw_done_d;
    logic          w_done_q, w_done_d;
    logic [GW-1:0] rd_start, wr_start;
    logic [NM-1:0] wr_req;
    logic          aw_vld, w_vld, aw_hs, w_hs;

    // First requester at or after start, wrapping at NM-1.
    function automatic logic [GW-1:0] pick(input logic [NM-1:0] req, input logic [GW-1:0] start);
        logic [GW-1:0] win;
        logic          found;
        win   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NM; i++) begin
            int unsigned idx;
            idx = (32'(start) + i) % NM;
            if (!found && req[idx]) begin
                win   = GW'(idx);
                found = 1'b1;
            end
        end
        return win;
    endfunction

    assign wr_req = bus_io.m_awvalid | bus_io.m_wvalid;

`ifdef AXI_ARB_ROUND_ROBIN_EN
    logic [GW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;

    function automatic logic [GW-1:0] inc_idx(input logic [GW-1:0] g);
        return (g == GW'(NM - 1)) ? '0 : g + GW'(1);
    endfunction

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (rd_state_q == RdData && bus_io.s_rvalid && bus_io.m_rready[rgnt_q]) begin
            rd_ptr_d = inc_idx(rgnt_q);
        end
        if (wr_state_q == WrResp && bus_io.s_bvalid && bus_io.m_bready[wgnt_q]) begin
            wr_ptr_d = inc_idx(wgnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    assign rd_start = rd_ptr_q;
    assign wr_start = wr_ptr_q;
`else
    assign rd_start = '0;
    assign wr_start = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state_q <= RdIdle;
            wr_state_q <= WrIdle;
            rgnt_q     <= '0;
            wgnt_q     <= '0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            rd_state_q <= rd_state_d;
            wr_state_q <= wr_state_d;
            rgnt_q     <= rgnt_d;
            wgnt_q     <= wgnt_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
        end
    end

    // Read arbiter
    always_comb begin
        rd_state_d       = rd_state_q;
        rgnt_d           = rgnt_q;
        bus_io.m_arready = '0;
        bus_io.m_rvalid  = '0;
        bus_io.s_arvalid = 1'b0;
        bus_io.s_rready  = 1'b0;
        case (rd_state_q)
            RdIdle: begin
                if (|bus_io.m_arvalid) begin
                    rgnt_d     = pick(bus_io.m_arvalid, rd_start);
                    rd_state_d = RdAddr;
                end
            end
            RdAddr: begin
                bus_io.s_arvalid         = bus_io.m_arvalid[rgnt_q];
                bus_io.m_arready[rgnt_q] = bus_io.s_arready;
                if (bus_io.m_arvalid[rgnt_q] && bus_io.s_arready) begin
                    rd_state_d = RdData;
                end
            end
            RdData: begin
                bus_io.m_rvalid[rgnt_q] = bus_io.s_rvalid;
                bus_io.s_rready         = bus_io.m_rready[rgnt_q];
                if (bus_io.s_rvalid && bus_io.m_rready[rgnt_q]) begin
                    rd_state_d = RdIdle;
                end
            end
            default: rd_state_d = RdIdle;
        endcase
    end

    // Write arbiter; AW and W may complete in either order, flags remember which is done.
    always_comb begin
        wr_state_d       = wr_state_q;
        wgnt_d           = wgnt_q;
        aw_done_d        = aw_done_q;
        w_done_d         = w_done_q;
        aw_vld           = 1'b0;
        w_vld            = 1'b0;
        aw_hs            = 1'b0;
        w_hs             = 1'b0;
        bus_io.m_awready = '0;
        bus_io.m_wready  = '0;
        bus_io.m_bvalid  = '0;
        bus_io.s_awvalid = 1'b0;
        bus_io.s_wvalid  = 1'b0;
        bus_io.s_bready  = 1'b0;
        case (wr_state_q)
            WrIdle: begin
                if (|wr_req) begin
                    wgnt_d     = pick(wr_req, wr_start);
                    wr_state_d = WrReq;
                end
            end
            WrReq: begin
                aw_vld                   = bus_io.m_awvalid[wgnt_q] && !aw_done_q;
                w_vld                    = bus_io.m_wvalid[wgnt_q] && !w_done_q;
                aw_hs                    = aw_vld && bus_io.s_awready;
                w_hs                     = w_vld && bus_io.s_wready;
                bus_io.s_awvalid         = aw_vld;
                bus_io.s_wvalid          = w_vld;
                bus_io.m_awready[wgnt_q] = bus_io.s_awready && !aw_done_q;
                bus_io.m_wready[wgnt_q]  = bus_io.s_wready && !w_done_q;
                aw_done_d                = aw_done_q | aw_hs;
                w_done_d                 = w_done_q | w_hs;
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    wr_state_d = WrResp;
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                end
            end
            WrResp: begin
                bus_io.m_bvalid[wgnt_q] = bus_io.s_bvalid;
                bus_io.s_bready         = bus_io.m_bready[wgnt_q];
                if (bus_io.s_bvalid && bus_io.m_bready[wgnt_q]) begin
                    wr_state_d = WrIdle;
                end
            end
            default: wr_state_d = WrIdle;
        endcase
    end

    // Slave payloads follow the registered grants only.
    always_comb begin
        bus_io.s_araddr = '0;
        bus_io.s_awaddr = '0;
        bus_io.s_wdata  = '0;
        bus_io.s_wstrb  = '0;
        for (int unsigned i = 0; i < NM; i++) begin
            if (rgnt_q == GW'(i)) begin
                bus_io.s_araddr = bus_io.m_araddr[i*AW +: AW];
            end
            if (wgnt_q == GW'(i)) begin
                bus_io.s_awaddr = bus_io.m_awaddr[i*AW +: AW];
                bus_io.s_wdata  = bus_io.m_wdata[i*DW +: DW];
                bus_io.s_wstrb  = bus_io.m_wstrb[i*SW +: SW];
            end
        end
    end

    assign bus_io.m_rdata = bus_io.s_rdata;
    assign bus_io.m_rresp = bus_io.s_rresp;
    assign bus_io.m_bresp = bus_io.s_bresp;

endmodule

// File: tb/tb_axi_lite_arbiter_n.sv
// Table-driven cycle-by-cycle bench for axi_lite_arbiter_n with NM=4, plus a repeated-read
// arbitration sequence whose expected winners depend on AXI_ARB_ROUND_ROBIN_EN.
module tb_axi_lite_arbiter_n;
    localparam int unsigned NM = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    axi_lite_arbiter_n_if #(.NM(NM), .AW(AW), .DW(DW)) bus ();

    axi_lite_arbiter_n #(.NM(NM), .AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus_io(bus)
    );

    // sl = {s_arready, s_rvalid, s_awready, s_wready, s_bvalid}
    // em = {m_arready, m_rvalid, m_awready, m_wready, m_bvalid} one hex digit each
    // es = {s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready}
    typedef struct {
        logic        rst;
        logic [3:0]  arv, rrdy, awv, wv, brdy;
        logic [4:0]  sl;
        logic [19:0] em;
        logic [4:0]  es;
        int          rg;
        int          wg;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [31:0] ar_addr(input int i);
        return 32'hA000_0000 + 32'(i) * 32'd16;
    endfunction
    function automatic logic [31:0] aw_addr(input int i);
        return 32'hB000_0000 + 32'(i) * 32'd16;
    endfunction
    function automatic logic [31:0] wdata_of(input int i);
        return 32'hD000_0000 + 32'(i);
    endfunction
    function automatic logic [3:0] strb_of(input int i);
        logic [3:0] one;
        one = 4'b0001;
        return one << i;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic [3:0] arv, input logic [3:0] rrdy,
                       input logic [3:0] awv, input logic [3:0] wv, input logic [3:0] brdy,
                       input logic [4:0] sl, input logic [19:0] em, input logic [4:0] es,
                       input int rg, input int wg);
        vec_t v;
        v.rst = rst; v.arv = arv; v.rrdy = rrdy; v.awv = awv; v.wv = wv; v.brdy = brdy;
        v.sl = sl; v.em = em; v.es = es; v.rg = rg; v.wg = wg;
        vecs.push_back(v);
    endtask

    task automatic drive_idle();
        bus.m_arvalid = '0; bus.m_rready = '0; bus.m_awvalid = '0; bus.m_wvalid = '0;
        bus.m_bready = '0;
        {bus.s_arready, bus.s_rvalid, bus.s_awready, bus.s_wready, bus.s_bvalid} = 5'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         exp_g;
        logic       found;
        logic [1:0] rsp;
        logic [3:0] one;

        // Reset state, then read m0/m1 contention with slave and master backpressure
        add(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 5'b00000, 20'h00000, 5'b00000, -1, -1);
        add(0, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 5'b00000, 20'h00000, 5'b00000, -1, -1);
        add(0, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 5'b10000, 20'h10000, 5'b10000,  0, -1);
        add(0, 4'h2, 4'h1, 4'h0, 4'h0, 4'h0, 5'b00000, 20'h00000, 5'b01000, -1, -1);
        add(0, 4'h2, 4'h1, 4'h0, 4'h0, 4'h0, 5'b01000, 20'h01000, 5'b01000, -1, -1);
        add(0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 5'b00000, 20'h00000, 5'b00000, -1, -1);
        add(0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 5'b00000, 20'h00000, 5'b10000,  1, -1);
        add(0, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 5'b10000, 20'h20000, 5'b10000,  1, -1);
        add(0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 5'b01000, 20'h02000, 5'b00000, -1, -1);
        add(0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 5'b01000, 20'h02000, 5'b01000, -1, -1);
        add(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 5'b00000, 20'h00000, 5'b00000, -1, -1);
        // m3: W first, AW three cycles later, then B with backpressure
        add(0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0, 5'b00000, 20'h00000, 5'b00000, -1, -1);
        add(0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0, 5'b00010, 20'h00080, 5'b00010, -1,  3);
        add(0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0, 5'b00010, 20'h00000, 5'b00000, -1, -1);
        add(0, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0, 5'b00100, 20'h00800, 5'b00100, -1,  3);
        add(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 5'b00001, 20'h00008, 5'b00000, -1, -1);
        add(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 5'b00001, 20'h00008, 5'b00001, -1, -1);
        add(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 5'b00000, 20'h00000, 5'b00000, -1, -1);
        // m0 read and m1 write together, zero slave wait
        add(0, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0, 5'b00000, 20'h00000, 5'b00000, -1, -1);
        add(0, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0, 5'b10110, 20'h10220, 5'b10110,  0,  1);
        add(0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h2, 5'b01001, 20'h01002, 5'b01001, -1, -1);
        add(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 5'b00000, 20'h00000, 5'b00000, -1, -1);
        // Reset while read is in RdData and write has AW done, then fresh transactions
        add(0, 4'h1, 4'h0, 4'h4, 4'h4, 4'h0, 5'b00000, 20'h00000, 5'b00000, -1, -1);
        add(0, 4'h1, 4'h0, 4'h4, 4'h4, 4'h0, 5'b10100, 20'h10400, 5'b10110,  0,  2);
        add(1, 4'h0, 4'h0, 4'h4, 4'h4, 4'h0, 5'b01000, 20'h01000, 5'b00010, -1,  2);
        add(0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 5'b01000, 20'h00000, 5'b00000, -1, -1);
        add(0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h0, 5'b00000, 20'h00000, 5'b00000, -1, -1);
        add(0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h0, 5'b00000, 20'h00000, 5'b10100,  1,  2);
        add(0, 4'h2, 4'h0, 4'h4, 4'h4, 4'h0, 5'b10110, 20'h20440, 5'b10110,  1,  2);
        add(0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h4, 5'b01001, 20'h02004, 5'b01001, -1, -1);
        add(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 5'b00000, 20'h00000, 5'b00000, -1, -1);

        for (int i = 0; i < int'(NM); i++) begin
            bus.m_araddr[i*AW +: AW]   = ar_addr(i);
            bus.m_awaddr[i*AW +: AW]   = aw_addr(i);
            bus.m_wdata[i*DW +: DW]    = wdata_of(i);
            bus.m_wstrb[i*4 +: 4]      = strb_of(i);
        end
        bus.s_rdata = '0; bus.s_rresp = 1'b0; bus.s_bresp = 1'b0;
        drive_idle();
        reset = 1'b1;
        repeat (2) @(negedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            reset         = vecs[i].rst;
            bus.m_arvalid = vecs[i].arv;
            bus.m_rready  = vecs[i].rrdy;
            bus.m_awvalid = vecs[i].awv;
            bus.m_wvalid  = vecs[i].wv;
            bus.m_bready  = vecs[i].brdy;
            {bus.s_arready, bus.s_rvalid, bus.s_awready, bus.s_wready, bus.s_bvalid} = vecs[i].sl;
            rsp           = 2'(i);
            bus.s_rdata   = 32'h5A00_0000 + 32'(i);
            bus.s_rresp   = rsp[0];
            bus.s_bresp   = rsp[1];
            #1;
            chk($sformatf("vec%0d_master", i),
                {bus.m_arready, bus.m_rvalid, bus.m_awready, bus.m_wready, bus.m_bvalid},
                vecs[i].em);
            chk($sformatf("vec%0d_slave", i),
                {bus.s_arvalid, bus.s_rready, bus.s_awvalid, bus.s_wvalid, bus.s_bready},
                vecs[i].es);
            chk($sformatf("vec%0d_rdata", i), bus.m_rdata, 32'h5A00_0000 + 32'(i));
            chk($sformatf("vec%0d_resp", i), {bus.m_bresp, bus.m_rresp}, rsp);
            if (vecs[i].rg >= 0) begin
                chk($sformatf("vec%0d_araddr", i), bus.s_araddr, ar_addr(vecs[i].rg));
            end
            if (vecs[i].wg >= 0 && vecs[i].es[2]) begin
                chk($sformatf("vec%0d_awaddr", i), bus.s_awaddr, aw_addr(vecs[i].wg));
            end
            if (vecs[i].wg >= 0 && vecs[i].es[1]) begin
                chk($sformatf("vec%0d_wdata", i), bus.s_wdata, wdata_of(vecs[i].wg));
                chk($sformatf("vec%0d_wstrb", i), bus.s_wstrb, strb_of(vecs[i].wg));
            end
        end

        // m0 and m1 both request on every cycle across ten reads
        @(negedge clk);
        reset = 1'b0;
        drive_idle();
        bus.m_arvalid = 4'h3;
        bus.m_rready  = 4'h3;
        bus.s_arready = 1'b1;
        bus.s_rvalid  = 1'b1;
        for (int k = 0; k < 10; k++) begin
`ifdef AXI_ARB_ROUND_ROBIN_EN
            exp_g = k % 2;
`else
            exp_g = 0;
`endif
            found = 1'b0;
            for (int n = 0; n < 4 && !found; n++) begin
                @(negedge clk);
                #1;
                if (bus.s_arvalid) found = 1'b1;
            end
            chk($sformatf("rd%0d_grant_seen", k), found, 1'b1);
            if (found) begin
                one = 4'b0001;
                chk($sformatf("rd%0d_araddr", k), bus.s_araddr, ar_addr(exp_g));
                chk($sformatf("rd%0d_arready", k), bus.m_arready, one << exp_g);
            end
        end
        @(negedge clk);
        drive_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
